uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver. It is the receive-side counterpart of the team's uart_tx.
- Samples an asynchronous 8N1 line (optional parity) at mid-bit, using a clock-count bit timer.
- Presents each received byte with a one-cycle valid strobe.
- Flags framing and parity errors.
- Sits between the board RX pin and the VDAS command/packet parser.

Parameters:
- CLKS_PER_BIT, 87: system clocks per bit period (e.g. 10 MHz / 115200). Must be >= 4.
- PARITY_EN, 0: 1 = a parity bit is expected after bit 7.
- PARITY_ODD, 0: parity sense when PARITY_EN=1. 0 = even, 1 = odd.

Ports:
- i_Clock  input  1  system clock; all logic on rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Rx_Serial  input  1  raw serial line; idle high; asynchronous to i_Clock.
- o_Rx_DV  output  1  one-cycle pulse; o_Rx_Byte is valid in the same cycle.
- o_Rx_Byte  output  8  last good byte, LSB received first; held until the next good byte.
- o_Rx_Active  output  1  high while a frame is in progress (from start detect until stop/error handling ends).
- o_Rx_Frame_Err  output  1  one-cycle pulse when the stop bit is sampled low.
- o_Rx_Parity_Err  output  1  one-cycle pulse when the parity check fails. Only ever pulses when PARITY_EN=1.

Behaviour:
- Reset (async, active-high):
  - Synchronizer flops = 1; state = IDLE; counters = 0.
  - o_Rx_DV = 0, o_Rx_Byte = 8'h00, o_Rx_Active = 0, o_Rx_Frame_Err = 0, o_Rx_Parity_Err = 0.
  - Reset asserted mid-frame aborts the frame immediately; no strobe is emitted.
- Input path:
  - i_Rx_Serial passes through a 2-flop synchronizer (adds 2 cycles of latency).
  - All decisions use the synchronized signal rx_s.
- Bit timer:
  - clk_cnt counts 0..CLKS_PER_BIT-1. Width = clog2(CLKS_PER_BIT).
  - bit_idx counts 0..7.
- IDLE:
  - o_Rx_Active = 0.
  - rx_s == 0 → START, clk_cnt = 0.
- START:
  - Sample when clk_cnt == (CLKS_PER_BIT-1)/2 (mid start bit).
  - rx_s == 0 → DATA, clk_cnt = 0, bit_idx = 0, o_Rx_Active = 1.
  - rx_s == 1 → glitch; return to IDLE with no outputs.
- DATA:
  - Sample when clk_cnt == CLKS_PER_BIT-1; shift rx_s into shreg[bit_idx]; clk_cnt = 0.
  - After bit_idx == 7 → PARITY if PARITY_EN, else STOP.
- PARITY:
  - Sample after CLKS_PER_BIT clocks.
  - par_bad = (^shreg ^ rx_s) != PARITY_ODD.
  - Go to STOP.
- STOP:
  - Sample after CLKS_PER_BIT clocks.
  - rx_s == 1 and !par_bad → next cycle: o_Rx_Byte = shreg and o_Rx_DV = 1 for exactly one cycle.
  - rx_s == 1 and par_bad → o_Rx_Parity_Err pulses 1 cycle; o_Rx_Byte unchanged; no DV.
  - rx_s == 0 → o_Rx_Frame_Err pulses 1 cycle (takes priority over parity; no DV; byte unchanged); go to BREAK.
  - In all non-BREAK cases go to CLEANUP.
- BREAK:
  - o_Rx_Active stays 1.
  - Wait until rx_s == 1, then go to CLEANUP. A held-low line never produces repeated errors.
- CLEANUP:
  - Exactly one cycle; o_Rx_Active = 0; pulse outputs return to 0; go to IDLE.
  - A start edge already present is detected from IDLE on the next cycle, so back-to-back frames are supported.
- Latency: o_Rx_DV rises 2 (sync) + 1 cycles after the stop-bit mid-sample, i.e. roughly 9.5 bit periods after the start edge.
- Reads on o_Rx_Byte are stable for ≥ 1 full frame; there is no FIFO. An unread byte is simply overwritten.

Test Plan (CLKS_PER_BIT=8 unless noted; bench drives the line from a uart_tx instance or a task):
- Reset, line idle, then send 0x3F → one o_Rx_DV pulse with o_Rx_Byte=0x3F; no error pulses; o_Rx_Active low afterward.
- Back-to-back 0x00 then 0xFF, no idle gap → two DV pulses with 0x00 then 0xFF; exactly 80 clocks ±1 between pulses.
- 2-clock low glitch on idle line → no DV, no error, o_Rx_Active stays 0, state returns to IDLE; then 0xA5 → received correctly.
- Send 0x55 with stop bit forced low, line held low 30 clocks, then high → single o_Rx_Frame_Err pulse, no DV, o_Rx_Byte keeps its previous value; subsequent 0x5A received.
- PARITY_EN=1, PARITY_ODD=0: send 0x81 with parity=0 → DV, byte 0x81. Send 0x81 with parity=1 → o_Rx_Parity_Err pulse, no DV.
- Assert i_Reset during data bit 4 of 0xC3, release, then send 0x12 → no output for the aborted frame; all outputs at reset values; 0x12 received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Serial UART receiver for an asynchronous 8N1 line, with an optional parity
// bit. The line is synchronised, start bits are qualified at mid-bit and every
// later bit is sampled one bit period after the previous sample. Each good byte
// is presented with a one-cycle valid strobe. Framing and parity errors are
// flagged with one-cycle pulses.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per bit period (>= 4)
//   PARITY_EN     1 = a parity bit follows data bit 7
//   PARITY_ODD    parity sense when PARITY_EN = 1 (0 = even, 1 = odd)
//
// Ports:
//   i_Clock          system clock, rising edge
//   i_Reset          asynchronous active-high reset
//   i_Rx_Serial      raw serial line, idle high, asynchronous to i_Clock
//   o_Rx_DV          one-cycle strobe, o_Rx_Byte valid in the same cycle
//   o_Rx_Byte        last good byte (LSB received first), held until the next
//   o_Rx_Active      high while a qualified frame is being handled
//   o_Rx_Frame_Err   one-cycle pulse when the stop bit is sampled low
//   o_Rx_Parity_Err  one-cycle pulse when the parity check fails
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Parity_Err
);

  localparam int unsigned    CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntMid  = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam bit              ParEn   = (PARITY_EN != 0);
  localparam logic            ParOdd  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak,
    StCleanup
  } state_t;

  state_t            r_state;
  logic              r_rx_meta;
  logic              r_rx_s;
  logic [CntW-1:0]   r_clk_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shreg;
  logic              r_par_bad;
  logic              r_rx_dv;
  logic [7:0]        r_rx_byte;
  logic              r_rx_active;
  logic              r_frame_err;
  logic              r_parity_err;

  logic              w_par_bad;

  // Total ones over data plus parity bit must match the configured sense.
  assign w_par_bad = ((^r_shreg) ^ r_rx_s) != ParOdd;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_rx_meta    <= 1'b1;
      r_rx_s       <= 1'b1;
      r_state      <= StIdle;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shreg      <= '0;
      r_par_bad    <= 1'b0;
      r_rx_dv      <= 1'b0;
      r_rx_byte    <= '0;
      r_rx_active  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_rx_meta <= i_Rx_Serial;
      r_rx_s    <= r_rx_meta;

      // Strobes default low so each one lasts exactly one cycle.
      r_rx_dv      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;

      case (r_state)
        StIdle: begin
          r_rx_active <= 1'b0;
          r_clk_cnt   <= '0;
          if (!r_rx_s) begin
            r_state <= StStart;
          end
        end

        StStart: begin
          if (r_clk_cnt == CntMid) begin
            r_clk_cnt <= '0;
            if (!r_rx_s) begin
              r_state     <= StData;
              r_bit_idx   <= '0;
              r_par_bad   <= 1'b0;
              r_rx_active <= 1'b1;
            end else begin
              // Line went back high before mid start bit: a glitch.
              r_state <= StIdle;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        StData: begin
          if (r_clk_cnt == CntLast) begin
            r_clk_cnt          <= '0;
            r_shreg[r_bit_idx] <= r_rx_s;
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= '0;
              r_state   <= ParEn ? StParity : StStop;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        StParity: begin
          if (r_clk_cnt == CntLast) begin
            r_clk_cnt <= '0;
            r_par_bad <= w_par_bad;
            r_state   <= StStop;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        StStop: begin
          if (r_clk_cnt == CntLast) begin
            r_clk_cnt <= '0;
            if (!r_rx_s) begin
              // Framing error wins over parity; wait out a held-low line.
              r_frame_err <= 1'b1;
              r_state     <= StBreak;
            end else begin
              if (r_par_bad) begin
                r_parity_err <= 1'b1;
              end else begin
                r_rx_dv   <= 1'b1;
                r_rx_byte <= r_shreg;
              end
              r_rx_active <= 1'b0;
              r_state     <= StCleanup;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        StBreak: begin
          if (r_rx_s) begin
            r_rx_active <= 1'b0;
            r_state     <= StCleanup;
          end
        end

        StCleanup: begin
          r_rx_active <= 1'b0;
          r_state     <= StIdle;
        end

        default: begin
          r_rx_active <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign o_Rx_DV         = r_rx_dv;
  assign o_Rx_Byte       = r_rx_byte;
  assign o_Rx_Active     = r_rx_active;
  assign o_Rx_Frame_Err  = r_frame_err;
  assign o_Rx_Parity_Err = r_parity_err;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Two receivers at 8 clocks per bit: one
// without parity (index 0) and one with even parity (index 1), each on its own
// serial line driven by tasks. Expected outcomes come from a hand-written
// vector table and from a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int unsigned Cpb = 8;
  localparam int          KDv = 0;
  localparam int          KFe = 1;
  localparam int          KPe = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       line0;
  logic       line1;

  logic       dv0, act0, fe0, pe0;
  logic [7:0] byte0;
  logic       dv1, act1, fe1, pe1;
  logic [7:0] byte1;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT(Cpb),
    .PARITY_EN   (0),
    .PARITY_ODD  (0)
  ) u_dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Rx_Serial    (line0),
    .o_Rx_DV        (dv0),
    .o_Rx_Byte      (byte0),
    .o_Rx_Active    (act0),
    .o_Rx_Frame_Err (fe0),
    .o_Rx_Parity_Err(pe0)
  );

  uart_rx #(
    .CLKS_PER_BIT(Cpb),
    .PARITY_EN   (1),
    .PARITY_ODD  (0)
  ) u_dut_par (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Rx_Serial    (line1),
    .o_Rx_DV        (dv1),
    .o_Rx_Byte      (byte1),
    .o_Rx_Active    (act1),
    .o_Rx_Frame_Err (fe1),
    .o_Rx_Parity_Err(pe1)
  );

  // ---------------------------------------------------------------- monitor
  int         cyc = 0;
  int         n_dv[2]  = '{0, 0};
  int         n_fe[2]  = '{0, 0};
  int         n_pe[2]  = '{0, 0};
  int         n_act[2] = '{0, 0};
  int         t_dv_prev = 0;
  int         t_dv_last = 0;
  logic [7:0] b_prev = 8'h00;
  logic [7:0] b_last = 8'h00;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dv0 === 1'b1) begin
      n_dv[0]   = n_dv[0] + 1;
      t_dv_prev = t_dv_last;
      t_dv_last = cyc;
      b_prev    = b_last;
      b_last    = byte0;
    end
    if (dv1 === 1'b1) n_dv[1] = n_dv[1] + 1;
    if (fe0 === 1'b1) n_fe[0] = n_fe[0] + 1;
    if (fe1 === 1'b1) n_fe[1] = n_fe[1] + 1;
    if (pe0 === 1'b1) n_pe[0] = n_pe[0] + 1;
    if (pe1 === 1'b1) n_pe[1] = n_pe[1] + 1;
    if (act0 === 1'b1) n_act[0] = n_act[0] + 1;
    if (act1 === 1'b1) n_act[1] = n_act[1] + 1;
  end

  // ---------------------------------------------------------------- checking
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ------------------------------------------------------- reference model
  // Frame-level outcome: stop low is a framing error; otherwise the parity
  // receiver rejects frames whose data+parity ones count is odd.
  function automatic int model_kind(input logic [7:0] d, input bit has_par, input bit p,
                                    input bit stop);
    if (!stop) return KFe;
    if (has_par && ((($countones(d) + int'(p)) % 2) != 0)) return KPe;
    return KDv;
  endfunction

  logic [7:0] m_byte[2] = '{8'h00, 8'h00};

  // ---------------------------------------------------------------- drivers
  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) line1 = v;
    else     line0 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit p, input bit stop);
    drive(sel, 1'b0, Cpb);
    for (int i = 0; i < 8; i++) drive(sel, d[i], Cpb);
    if (sel) drive(sel, p, Cpb);
    drive(sel, stop, Cpb);
  endtask

  task automatic run_frame(input string name, input bit sel, input logic [7:0] d, input bit p,
                           input bit stop, input int hold_low, input int gap,
                           input int exp_kind, input logic [7:0] exp_byte);
    int s_dv, s_fe, s_pe;
    s_dv = n_dv[sel];
    s_fe = n_fe[sel];
    s_pe = n_pe[sel];
    send_frame(sel, d, p, stop);
    if (!stop) drive(sel, 1'b0, hold_low);
    drive(sel, 1'b1, gap);
    chk({name, ".dv"}, n_dv[sel] - s_dv, (exp_kind == KDv) ? 1 : 0);
    chk({name, ".fe"}, n_fe[sel] - s_fe, (exp_kind == KFe) ? 1 : 0);
    chk({name, ".pe"}, n_pe[sel] - s_pe, (exp_kind == KPe) ? 1 : 0);
    chk({name, ".byte"}, sel ? byte1 : byte0, exp_byte);
    chk({name, ".active"}, sel ? act1 : act0, 0);
    m_byte[sel] = exp_byte;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    bit         sel;
    logic [7:0] data;
    bit         p;
    bit         stop;
    int         hold_low;
    int         exp_kind;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int s_dv, s_fe, s_pe, s_act, diff;

    vecs[0] = '{0, 8'h3F, 1'b0, 1'b1, 0,  KDv, 8'h3F};
    vecs[1] = '{0, 8'hA5, 1'b0, 1'b1, 0,  KDv, 8'hA5};
    vecs[2] = '{0, 8'h55, 1'b0, 1'b0, 30, KFe, 8'hA5};
    vecs[3] = '{0, 8'h5A, 1'b0, 1'b1, 0,  KDv, 8'h5A};
    vecs[4] = '{1, 8'h81, 1'b0, 1'b1, 0,  KDv, 8'h81};
    vecs[5] = '{1, 8'h81, 1'b1, 1'b1, 0,  KPe, 8'h81};
    vecs[6] = '{1, 8'h7E, 1'b0, 1'b1, 0,  KDv, 8'h7E};
    vecs[7] = '{1, 8'h01, 1'b0, 1'b1, 0,  KPe, 8'h7E};
    vecs[8] = '{1, 8'h01, 1'b1, 1'b1, 0,  KDv, 8'h01};
    vecs[9] = '{1, 8'hF0, 1'b1, 1'b0, 5,  KFe, 8'h01};

    // Reset state
    rst   = 1'b1;
    line0 = 1'b1;
    line1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.dv",     dv0,   0);
    chk("rst.byte",   byte0, 8'h00);
    chk("rst.active", act0,  0);
    chk("rst.fe",     fe0,   0);
    chk("rst.pe",     pe0,   0);
    chk("rst.byte_p", byte1, 8'h00);
    chk("rst.act_p",  act1,  0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Two-clock glitch on the idle line must be ignored entirely
    s_dv  = n_dv[0];
    s_fe  = n_fe[0];
    s_act = n_act[0];
    drive(0, 1'b0, 2);
    drive(0, 1'b1, 20);
    chk("glitch.dv",     n_dv[0] - s_dv,   0);
    chk("glitch.fe",     n_fe[0] - s_fe,   0);
    chk("glitch.active", n_act[0] - s_act, 0);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].data, vecs[i].p, vecs[i].stop,
                vecs[i].hold_low, 12, vecs[i].exp_kind, vecs[i].exp_byte);
    end

    // Back-to-back frames with no idle gap: pulses one frame (80 clocks) apart
    s_dv = n_dv[0];
    send_frame(0, 8'h00, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1);
    drive(0, 1'b1, 12);
    diff = t_dv_last - t_dv_prev;
    chk("b2b.count",   n_dv[0] - s_dv, 2);
    chk("b2b.first",   b_prev, 8'h00);
    chk("b2b.second",  b_last, 8'hFF);
    chk("b2b.spacing", (diff >= 79 && diff <= 81) ? diff : -1, 80 + (diff - 80));
    chk("b2b.spacing_exact80pm1", (diff >= 79 && diff <= 81) ? 1 : 0, 1);
    chk("b2b.byte",    byte0, 8'hFF);
    m_byte[0] = 8'hFF;

    // Reset in the middle of data bit 4 of 0xC3 aborts the frame silently
    s_dv = n_dv[0];
    s_fe = n_fe[0];
    s_pe = n_pe[0];
    drive(0, 1'b0, Cpb);
    for (int i = 0; i < 4; i++) drive(0, 1'(8'hC3 >> i), Cpb);
    drive(0, 1'b0, 4);
    rst   = 1'b1;
    line0 = 1'b1;
    @(negedge clk);
    chk("midrst.dv",     dv0,   0);
    chk("midrst.byte",   byte0, 8'h00);
    chk("midrst.active", act0,  0);
    chk("midrst.fe",     fe0,   0);
    chk("midrst.pe",     pe0,   0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("midrst.no_dv", n_dv[0] - s_dv, 0);
    chk("midrst.no_fe", n_fe[0] - s_fe, 0);
    chk("midrst.no_pe", n_pe[0] - s_pe, 0);
    chk("midrst.hold",  byte0, 8'h00);
    chk("midrst.act2",  act0,  0);
    m_byte[0] = 8'h00;
    m_byte[1] = 8'h00;
    run_frame("after_rst", 0, 8'h12, 1'b0, 1'b1, 0, 12, KDv, 8'h12);

    // Randomised frames against the frame-level model
    for (int i = 0; i < 30; i++) begin
      bit         sel;
      logic [7:0] d;
      bit         p;
      bit         stop;
      int         kind;
      sel  = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      p    = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 9) != 0);
      kind = model_kind(d, sel, p, stop);
      run_frame($sformatf("rnd%0d", i), sel, d, p, stop, $urandom_range(0, 20),
                $urandom_range(6, 24), kind, (kind == KDv) ? d : m_byte[sel]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
